// File: rtl/calc_pkg.sv
// Shared types and constants for the decimal adder sequencer.
// Optional watchdog feature is enabled by defining CALC_TIMEOUT_EN.
package calc_pkg;

  typedef enum logic [2:0] {
    S_ENTRY_A,
    S_ENTRY_B,
    S_SUM,
    S_CONV,
    S_SHOW,
    S_ERR
  } state_t;

  localparam logic [1:0] DISP_A   = 2'd0;
  localparam logic [1:0] DISP_B   = 2'd1;
  localparam logic [1:0] DISP_RES = 2'd2;
  localparam logic [1:0] DISP_ERR = 2'd3;

  localparam int unsigned CALC_MAX_DIGITS = 3;

  // Display source selected while sitting in a given state
  function automatic logic [1:0] disp_of(input state_t s);
    case (s)
      S_ENTRY_A: disp_of = DISP_A;
      S_ENTRY_B: disp_of = DISP_B;
      S_ERR:     disp_of = DISP_ERR;
      default:   disp_of = DISP_RES;
    endcase
  endfunction

endpackage

// File: rtl/module_acumulador_digitos.sv
// One decimal-entry operand: binary value register plus accepted-digit count.
// clear and load in the same cycle restarts the operand with that digit.
module module_acumulador_digitos
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned MAX_DIGITS = CALC_MAX_DIGITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [3:0]        digit,
  output logic [DATA_W-1:0] value
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  logic [DATA_W-1:0]   r_value;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   w_base_val;
  logic [CNT_W-1:0]    w_base_cnt;
  logic                w_accept;
  logic [DATA_W+3:0]   w_prod;

  // Accept rule and value*10+digit, evaluated on the (possibly cleared) base
  always_comb begin
    w_base_val = clear ? '0 : r_value;
    w_base_cnt = clear ? '0 : r_cnt;
    w_accept   = load && (digit <= 4'd9) && (w_base_cnt < CNT_W'(MAX_DIGITS));
    w_prod     = ({4'b0000, w_base_val} * (DATA_W+4)'(10)) + {{DATA_W{1'b0}}, digit};
  end

  // Operand and digit-count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_value <= w_prod[DATA_W-1:0];
      r_cnt   <= w_base_cnt + CNT_W'(1);
    end else begin
      r_value <= w_base_val;
      r_cnt   <= w_base_cnt;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/module_control_calc.sv
// Sequencer for the two-operand decimal adder: digit entry for A and B,
// adder start/wait, BCD conversion start/wait, display source steering.
// Define CALC_TIMEOUT_EN to add the per-wait watchdog and the S_ERR state.
module module_control_calc
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W         = 12,
  parameter int unsigned MAX_DIGITS     = CALC_MAX_DIGITS,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              digit_valid,
  input  logic [3:0]        digit,
  input  logic              next_btn,
  input  logic              suma_btn,
  input  logic              clear_btn,
  input  logic              sum_done,
  input  logic              conv_listo,
  output logic [DATA_W-1:0] first_num,
  output logic [DATA_W-1:0] second_num,
  output logic              sum_go,
  output logic              conv_go,
  output logic [1:0]        disp_sel,
  output logic              busy,
  output logic              error
);

  state_t     r_state;
  state_t     w_next;
  logic       w_clr;
  logic       w_load_a;
  logic       w_load_b;
  logic       r_sum_go;
  logic       r_conv_go;
  logic [1:0] r_disp_sel;
  logic       r_busy;

`ifdef CALC_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            w_wd_exp;
  logic            r_error;
  assign w_wd_exp = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  module_acumulador_digitos #(.DATA_W(DATA_W), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
    .clk(clk), .rst(rst), .load(w_load_a), .clear(w_clr), .digit(digit), .value(first_num)
  );

  module_acumulador_digitos #(.DATA_W(DATA_W), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
    .clk(clk), .rst(rst), .load(w_load_b), .clear(w_clr), .digit(digit), .value(second_num)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_ENTRY_A;
    else     r_state <= w_next;
  end

  // Next state and operand load/clear strobes; clear_btn overrides everything.
  // done/listo are masked while the go pulse is still high (the go cycle).
  always_comb begin
    w_next   = r_state;
    w_clr    = 1'b0;
    w_load_a = 1'b0;
    w_load_b = 1'b0;
    if (clear_btn) begin
      w_next = S_ENTRY_A;
      w_clr  = 1'b1;
    end else begin
      case (r_state)
        S_ENTRY_A: begin
          w_load_a = digit_valid;
          if (next_btn) w_next = S_ENTRY_B;
        end
        S_ENTRY_B: begin
          w_load_b = digit_valid;
          if (suma_btn) w_next = S_SUM;
        end
        S_SUM: begin
          if (sum_done && !r_sum_go) w_next = S_CONV;
`ifdef CALC_TIMEOUT_EN
          else if (w_wd_exp)         w_next = S_ERR;
`endif
        end
        S_CONV: begin
          if (conv_listo && !r_conv_go) w_next = S_SHOW;
`ifdef CALC_TIMEOUT_EN
          else if (w_wd_exp)            w_next = S_ERR;
`endif
        end
        S_SHOW: begin
          if (digit_valid) begin
            w_clr    = 1'b1;
            w_load_a = 1'b1;
            w_next   = S_ENTRY_A;
          end
        end
`ifdef CALC_TIMEOUT_EN
        S_ERR: begin
          if (suma_btn) w_next = S_SUM;
        end
`endif
        default: w_next = S_ENTRY_A;
      endcase
    end
  end

  // Registered outputs derived from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_go   <= 1'b0;
      r_conv_go  <= 1'b0;
      r_disp_sel <= DISP_A;
      r_busy     <= 1'b0;
    end else begin
      r_sum_go   <= (w_next == S_SUM)  && (r_state != S_SUM);
      r_conv_go  <= (w_next == S_CONV) && (r_state != S_CONV);
      r_disp_sel <= disp_of(w_next);
      r_busy     <= (w_next == S_SUM) || (w_next == S_CONV);
    end
  end

`ifdef CALC_TIMEOUT_EN
  // Watchdog: cycles spent in the current SUM/CONV wait, restarted on entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      if ((w_next == r_state) && ((r_state == S_SUM) || (r_state == S_CONV)))
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      else
        r_wd_cnt <= '0;
      r_error <= (w_next == S_ERR);
    end
  end
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign sum_go   = r_sum_go;
  assign conv_go  = r_conv_go;
  assign disp_sel = r_disp_sel;
  assign busy     = r_busy;

endmodule

// File: tb/tb_module_control_calc.sv
// Directed self-checking bench for module_control_calc.
// Build with CALC_TIMEOUT_EN defined to also exercise the watchdog path.
module tb_module_control_calc;

  logic        clk = 1'b0;
  logic        rst;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        next_btn;
  logic        suma_btn;
  logic        clear_btn;
  logic        sum_done;
  logic        conv_listo;
  logic [11:0] first_num;
  logic [11:0] second_num;
  logic        sum_go;
  logic        conv_go;
  logic [1:0]  disp_sel;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;
  int sum_go_cnt = 0;
  int conv_go_cnt = 0;
  int g0;
  int c0;

  module_control_calc #(
    .DATA_W(12),
    .MAX_DIGITS(3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .next_btn(next_btn), .suma_btn(suma_btn), .clear_btn(clear_btn),
    .sum_done(sum_done), .conv_listo(conv_listo),
    .first_num(first_num), .second_num(second_num),
    .sum_go(sum_go), .conv_go(conv_go), .disp_sel(disp_sel),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Count go pulses (each lasts a full cycle, so one negedge sample each)
  always @(negedge clk) begin
    if (sum_go === 1'b1)  sum_go_cnt++;
    if (conv_go === 1'b1) conv_go_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [3:0] d);
    digit = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic press_next();
    next_btn = 1'b1; tick(); next_btn = 1'b0;
  endtask

  task automatic press_suma();
    suma_btn = 1'b1; tick(); suma_btn = 1'b0;
  endtask

  task automatic press_clear();
    clear_btn = 1'b1; tick(); clear_btn = 1'b0;
  endtask

  initial begin
    rst = 1'b1; digit_valid = 1'b0; digit = 4'd0; next_btn = 1'b0;
    suma_btn = 1'b0; clear_btn = 1'b0; sum_done = 1'b0; conv_listo = 1'b0;
    tick(); tick();
    check("rst_first", first_num, 0);
    check("rst_second", second_num, 0);
    check("rst_sum_go", sum_go, 0);
    check("rst_conv_go", conv_go, 0);
    check("rst_disp", disp_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    rst = 1'b0;
    tick();

    // 1: 123 + 456 full sequence
    key(1); key(2); key(3);
    check("t1_first", first_num, 123);
    check("t1_disp_a", disp_sel, 0);
    press_next();
    check("t1_disp_b", disp_sel, 1);
    key(4); key(5); key(6);
    check("t1_second", second_num, 456);
    g0 = sum_go_cnt; c0 = conv_go_cnt;
    press_suma();
    check("t1_sum_go", sum_go, 1);
    check("t1_busy_sum", busy, 1);
    check("t1_disp_sum", disp_sel, 2);
    tick(); tick();
    check("t1_sum_go_low", sum_go, 0);
    check("t1_busy_wait", busy, 1);
    sum_done = 1'b1; tick(); sum_done = 1'b0;
    check("t1_conv_go", conv_go, 1);
    check("t1_busy_conv", busy, 1);
    repeat (4) tick();
    check("t1_busy_conv_wait", busy, 1);
    conv_listo = 1'b1; tick(); conv_listo = 1'b0;
    check("t1_disp_show", disp_sel, 2);
    check("t1_busy_show", busy, 0);
    check("t1_sum_go_pulses", sum_go_cnt - g0, 1);
    check("t1_conv_go_pulses", conv_go_cnt - c0, 1);
    check("t1_first_kept", first_num, 123);
    key(8);
    check("t1_show_first", first_num, 8);
    check("t1_show_second", second_num, 0);
    check("t1_show_disp", disp_sel, 0);

    // 2: digit limit and out-of-range digit
    press_clear();
    check("t2_cleared", first_num, 0);
    key(12);
    check("t2_digit12", first_num, 0);
    key(9); key(9); key(9); key(7);
    check("t2_max", first_num, 999);

    // 3: suma in A ignored; digit and next together
    press_clear();
    g0 = sum_go_cnt;
    press_suma();
    check("t3_no_sum_go", sum_go_cnt - g0, 0);
    check("t3_disp_a", disp_sel, 0);
    digit = 4'd5; digit_valid = 1'b1; next_btn = 1'b1;
    tick();
    digit_valid = 1'b0; next_btn = 1'b0;
    check("t3_first", first_num, 5);
    check("t3_disp_b", disp_sel, 1);
    press_next();
    check("t3_next_in_b", disp_sel, 1);
    key(7);
    check("t3_second", second_num, 7);

    // 4: done in go cycle ignored; clear beats listo in S_CONV
    press_suma();
    check("t4_sum_go", sum_go, 1);
    sum_done = 1'b1; tick(); sum_done = 1'b0;
    check("t4_done_in_go_ignored", conv_go, 0);
    check("t4_still_busy", busy, 1);
    sum_done = 1'b1; tick(); sum_done = 1'b0;
    check("t4_conv_go", conv_go, 1);
    tick();
    conv_listo = 1'b1; clear_btn = 1'b1;
    tick();
    conv_listo = 1'b0; clear_btn = 1'b0;
    check("t4_disp", disp_sel, 0);
    check("t4_first", first_num, 0);
    check("t4_second", second_num, 0);
    check("t4_busy", busy, 0);
    tick();
    check("t4_no_show", disp_sel, 0);

    // 5: asynchronous reset in the middle of S_SUM
    key(2); press_next(); key(3); press_suma();
    tick();
    check("t5_busy_before", busy, 1);
    #3 rst = 1'b1;
    #1;
    check("t5_first", first_num, 0);
    check("t5_second", second_num, 0);
    check("t5_busy", busy, 0);
    check("t5_disp", disp_sel, 0);
    check("t5_sum_go", sum_go, 0);
    check("t5_error", error, 0);
    #2 rst = 1'b0;
    tick();

`ifdef CALC_TIMEOUT_EN
    // 6: watchdog expiry and retry
    key(4); press_next(); key(6); press_suma();
    check("t6_sum_go", sum_go, 1);
    repeat (15) tick();
    check("t6_error_early", error, 0);
    check("t6_disp_early", disp_sel, 2);
    tick();
    check("t6_error", error, 1);
    check("t6_disp_err", disp_sel, 3);
    check("t6_busy_err", busy, 0);
    g0 = sum_go_cnt;
    press_suma();
    check("t6_retry_go", sum_go, 1);
    check("t6_retry_error", error, 0);
    check("t6_first", first_num, 4);
    check("t6_second", second_num, 6);
    tick();
    check("t6_retry_go_low", sum_go, 0);
    check("t6_retry_pulses", sum_go_cnt - g0, 1);
    press_clear();
    check("t6_clear_disp", disp_sel, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
